acc_loader: RTL and testbench

- Upstream feeder for the block-matching accelerator.
- Accepts one job as a byte stream with valid/ready handshake: 256 current-block pixels (16x16), then 1024 search-window pixels (32x32), both raster order.
- Writes the pixels into the accelerator's current-block and search memory write ports, pulses start, waits for finish, then reports completion.
- Gives the host a single streaming interface instead of two raw memory write ports.

---
 rtl/acc_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_acc_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_loader.sv
// -----------------------------------------------------------------------------
// acc_loader
//   Upstream feeder for the block-matching accelerator. One job arrives as a
//   byte stream (valid/ready): 256 current-block pixels followed by 1024
//   search-window pixels, both raster order. Pixels are written into the
//   accelerator's current-block and search memories, the accelerator is
//   started, and the loader reports completion once the accelerator finishes.
//
//   Optional build macro: ACC_LOADER_CSUM_EN
//     defined   -> csum_o carries a 16-bit wrapping sum of the job's bytes
//     undefined -> csum_o is tied to 0 and no accumulator is built
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   load_req_i             request a new job (sampled while idle)
//   s_valid_i/s_ready_o    stream handshake
//   s_data_i, s_last_i     pixel byte, final-beat marker
//   curr_we_o/waddr/wdata  current-block memory write port (registered)
//   search_we_o/waddr/wdata search-window memory write port (registered)
//   acc_start_o            one-cycle accelerator start pulse
//   acc_finish_i           accelerator finish
//   acc_busy_i             accelerator busy (blocks a new load)
//   busy_o                 loader not idle
//   done_o                 one-cycle job-complete pulse
//   err_o                  sticky framing error
//   csum_o                 stream checksum (see macro above)
// -----------------------------------------------------------------------------
module acc_loader #(
  parameter int CURR_BYTES   = 256,
  parameter int SEARCH_BYTES = 1024,
  parameter int CURR_AW      = 8,
  parameter int SEARCH_AW    = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_req_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [7:0]           s_data_i,
  input  logic                 s_last_i,
  output logic                 curr_we_o,
  output logic [CURR_AW-1:0]   curr_waddr_o,
  output logic [7:0]           curr_wdata_o,
  output logic                 search_we_o,
  output logic [SEARCH_AW-1:0] search_waddr_o,
  output logic [7:0]           search_wdata_o,
  output logic                 acc_start_o,
  input  logic                 acc_finish_i,
  input  logic                 acc_busy_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [15:0]          csum_o
);

  localparam logic [10:0] LAST_CURR = 11'(CURR_BYTES - 1);
  localparam logic [10:0] LAST_BEAT = 11'(CURR_BYTES + SEARCH_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_CURR = 3'd1,
    LD_SRCH = 3'd2,
    KICK    = 3'd3,
    WAIT    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 next_s;
  logic [10:0]            cnt_r;
  logic                   curr_we_r;
  logic [CURR_AW-1:0]     curr_waddr_r;
  logic [7:0]             curr_wdata_r;
  logic                   search_we_r;
  logic [SEARCH_AW-1:0]   search_waddr_r;
  logic [7:0]             search_wdata_r;
  logic                   start_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   err_r;

  logic                   ready_s;
  logic                   beat_acc_s;
  logic                   load_acc_s;
  logic                   err_set_s;
  logic                   wr_curr_s;
  logic                   wr_srch_s;
  logic                   start_set_s;
  logic [SEARCH_AW-1:0]   srch_off_s;

  // Ready is a pure decode of the registered state, so it never glitches.
  assign ready_s    = (state_r == LD_CURR) || (state_r == LD_SRCH);
  assign beat_acc_s = s_valid_i && ready_s;
  // Search beats are numbered after the current block; rebase to address 0.
  assign srch_off_s = SEARCH_AW'(cnt_r - 11'(CURR_BYTES));

  // Next-state and per-cycle control strobes.
  always_comb begin
    next_s      = state_r;
    load_acc_s  = 1'b0;
    err_set_s   = 1'b0;
    wr_curr_s   = 1'b0;
    wr_srch_s   = 1'b0;
    start_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_req_i && !acc_busy_i) begin
          next_s     = LD_CURR;
          load_acc_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      LD_CURR: begin
        if (beat_acc_s) begin
          wr_curr_s = 1'b1;
          if (s_last_i) begin
            // Early last marker: the beat is still written, then abort.
            err_set_s = 1'b1;
            next_s    = IDLE;
          end else if (cnt_r == LAST_CURR) begin
            next_s = LD_SRCH;
          end else begin
            next_s = LD_CURR;
          end
        end else begin
          next_s = LD_CURR;
        end
      end
      LD_SRCH: begin
        if (beat_acc_s) begin
          wr_srch_s = 1'b1;
          if (cnt_r == LAST_BEAT) begin
            if (s_last_i) begin
              next_s = KICK;
            end else begin
              err_set_s = 1'b1;
              next_s    = IDLE;
            end
          end else if (s_last_i) begin
            err_set_s = 1'b1;
            next_s    = IDLE;
          end else begin
            next_s = LD_SRCH;
          end
        end else begin
          next_s = LD_SRCH;
        end
      end
      KICK: begin
        // Final search write is on the port this cycle; start follows it.
        start_set_s = 1'b1;
        next_s      = WAIT;
      end
      WAIT: begin
        if (acc_finish_i) begin
          next_s = DONE;
        end else begin
          next_s = WAIT;
        end
      end
      DONE: begin
        next_s = IDLE;
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State, beat counter, registered write ports and status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r        <= IDLE;
      cnt_r          <= 11'd0;
      curr_we_r      <= 1'b0;
      curr_waddr_r   <= '0;
      curr_wdata_r   <= 8'd0;
      search_we_r    <= 1'b0;
      search_waddr_r <= '0;
      search_wdata_r <= 8'd0;
      start_r        <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      state_r     <= next_s;
      curr_we_r   <= wr_curr_s;
      search_we_r <= wr_srch_s;
      if (wr_curr_s) begin
        curr_waddr_r <= CURR_AW'(cnt_r);
        curr_wdata_r <= s_data_i;
      end
      if (wr_srch_s) begin
        search_waddr_r <= srch_off_s;
        search_wdata_r <= s_data_i;
      end
      if (load_acc_s) begin
        cnt_r <= 11'd0;
      end else if (beat_acc_s) begin
        cnt_r <= cnt_r + 11'd1;
      end
      if (load_acc_s) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end
      start_r <= start_set_s;
      busy_r  <= (next_s != IDLE);
      done_r  <= (next_s == DONE);
    end
  end

`ifdef ACC_LOADER_CSUM_EN
  logic [15:0] csum_r;

  // Wrapping byte sum of the current job, cleared when a load is accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      csum_r <= 16'd0;
    end else if (load_acc_s) begin
      csum_r <= 16'd0;
    end else if (beat_acc_s) begin
      csum_r <= csum_r + {8'd0, s_data_i};
    end
  end

  assign csum_o = csum_r;
`else
  assign csum_o = 16'd0;
`endif

  assign s_ready_o      = ready_s;
  assign curr_we_o      = curr_we_r;
  assign curr_waddr_o   = curr_waddr_r;
  assign curr_wdata_o   = curr_wdata_r;
  assign search_we_o    = search_we_r;
  assign search_waddr_o = search_waddr_r;
  assign search_wdata_o = search_wdata_r;
  assign acc_start_o    = start_r;
  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign err_o          = err_r;

endmodule

// File: tb/tb_acc_loader.sv
// -----------------------------------------------------------------------------
// tb_acc_loader
//   Randomized scoreboard bench for acc_loader. The stimulus side pushes the
//   events a job must produce (memory writes, start, done) into a queue; a
//   negedge monitor pops and compares whenever the DUT shows one of them.
// -----------------------------------------------------------------------------
module tb_acc_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        curr_we;
  logic [7:0]  curr_waddr;
  logic [7:0]  curr_wdata;
  logic        search_we;
  logic [9:0]  search_waddr;
  logic [7:0]  search_wdata;
  logic        acc_start;
  logic        acc_finish;
  logic        acc_busy;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] csum;

  acc_loader dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .load_req_i     (load_req),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .s_data_i       (s_data),
    .s_last_i       (s_last),
    .curr_we_o      (curr_we),
    .curr_waddr_o   (curr_waddr),
    .curr_wdata_o   (curr_wdata),
    .search_we_o    (search_we),
    .search_waddr_o (search_waddr),
    .search_wdata_o (search_wdata),
    .acc_start_o    (acc_start),
    .acc_finish_i   (acc_finish),
    .acc_busy_i     (acc_busy),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .csum_o         (csum)
  );

  always #5 clk = ~clk;

  // Event kinds expected on the DUT outputs.
  localparam int EV_CURR  = 0;
  localparam int EV_SRCH  = 1;
  localparam int EV_START = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_wr_cyc = -10;
  int   fin_cyc = -10;
  bit   start_seen;
  bit   done_seen;
  logic [7:0] shadow_curr [0:255];
  logic [7:0] shadow_srch [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_event(input int kind, input int addr, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h expected none (cycle %0d)",
               kind, addr, data, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event", (kind << 24) | (addr << 8) | data,
            (e.kind << 24) | (e.addr << 8) | e.data);
    end
  endtask

  // Monitor: compares every output event against the scoreboard queue.
  always @(negedge clk) begin
    if (curr_we && search_we) check("we_exclusive", 32'd1, 32'd0);
    if (curr_we) begin
      pop_event(EV_CURR, int'(curr_waddr), int'(curr_wdata));
      shadow_curr[curr_waddr] = curr_wdata;
    end
    if (search_we) begin
      pop_event(EV_SRCH, int'(search_waddr), int'(search_wdata));
      shadow_srch[search_waddr] = search_wdata;
      last_wr_cyc = cyc;
    end
    if (acc_start) begin
      pop_event(EV_START, 0, 0);
      check("start_timing", cyc, last_wr_cyc + 1);
      start_seen = 1'b1;
    end
    if (done) begin
      pop_event(EV_DONE, 0, 0);
      check("done_timing", cyc, fin_cyc + 1);
      done_seen = 1'b1;
    end
    if (acc_finish) fin_cyc = cyc;
  end

  task automatic push_ev(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat after 'gap' idle cycles; ok=1 once it is accepted.
  task automatic send_beat(input logic [7:0] d, input logic last, input int gap, output bit ok);
    logic rdy;
    s_valid = 1'b0;
    repeat (gap) step();
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      rdy = s_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) check("beat_timeout", 32'd0, 32'd1);
  endtask

  // One job. last_at: beat carrying s_last (-1 = none). abort_at: beat index
  // before which reset is pulsed (-1 = never).
  task automatic run_job(input int last_at, input bit gaps, input bit rnd_data,
                         input int abort_at, input bit do_load);
    int   job_sum;
    bit   bad;
    bit   ok;
    int   gap;
    logic [7:0] d;
    logic last;
    job_sum    = 0;
    bad        = 1'b0;
    start_seen = 1'b0;
    done_seen  = 1'b0;
    if (do_load) begin
      load_req = 1'b1;
      step();
      load_req = 1'b0;
    end
    check("err_cleared_on_load", err, 32'd0);
    check("ready_after_load", s_ready, 32'd1);
    check("busy_after_load", busy, 32'd1);
    for (int n = 0; n < 1280; n++) begin
      if (n == abort_at) begin
        rst_n = 1'b0;
        step();
        check("abort_outputs_zero",
              |{s_ready, curr_we, curr_waddr, curr_wdata, search_we, search_waddr,
                search_wdata, acc_start, busy, done, err, csum}, 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        check("abort_no_start", start_seen, 32'd0);
        check("abort_queue_empty", exp_q.size(), 32'd0);
        return;
      end
      d    = rnd_data ? 8'($urandom_range(0, 255)) : 8'(n % 256);
      last = (n == last_at);
      gap  = gaps ? (($urandom_range(0, 1) == 1) ? $urandom_range(1, 2) : 0) : 0;
      send_beat(d, last, gap, ok);
      if (!ok) return;
      if (n < 256) push_ev(EV_CURR, n, int'(d));
      else         push_ev(EV_SRCH, n - 256, int'(d));
      job_sum += int'(d);
      if (last != (n == 1279)) begin
        bad = 1'b1;
        break;
      end
    end
    if (bad) begin
      repeat (3) step();
      check("err_set", err, 32'd1);
      check("err_back_idle", busy, 32'd0);
      check("err_not_ready", s_ready, 32'd0);
      check("err_no_start", start_seen, 32'd0);
    end else begin
      push_ev(EV_START, 0, 0);
      for (int t = 0; t < 10 && !start_seen; t++) step();
      check("start_seen", start_seen, 32'd1);
      repeat (3) step();
      check("busy_in_wait", busy, 32'd1);
      check("no_done_before_finish", done_seen, 32'd0);
      push_ev(EV_DONE, 0, 0);
      acc_finish = 1'b1;
      step();
      acc_finish = 1'b0;
      for (int t = 0; t < 10 && !done_seen; t++) step();
      check("done_seen", done_seen, 32'd1);
      step();
      check("idle_after_done", busy, 32'd0);
      check("err_clear_nominal", err, 32'd0);
    end
`ifdef ACC_LOADER_CSUM_EN
    check("csum", csum, job_sum & 32'hFFFF);
`else
    check("csum", csum, 32'd0);
`endif
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    load_req   = 1'b0;
    s_valid    = 1'b0;
    s_data     = 8'd0;
    s_last     = 1'b0;
    acc_finish = 1'b0;
    acc_busy   = 1'b0;
    start_seen = 1'b0;
    done_seen  = 1'b0;
    repeat (3) step();
    check("reset_outputs_zero",
          |{s_ready, curr_we, curr_waddr, curr_wdata, search_we, search_waddr,
            search_wdata, acc_start, busy, done, err, csum}, 32'd0);
    rst_n = 1'b1;
    step();

    // finish while idle must not produce done
    acc_finish = 1'b1;
    step();
    acc_finish = 1'b0;
    repeat (2) step();
    check("finish_ignored_idle", busy, 32'd0);

    // nominal incrementing job
    run_job(1279, 1'b0, 1'b0, -1, 1'b1);
    check("curr_mem_05", shadow_curr[5], 32'h05);
    check("srch_mem_3ff", shadow_srch[1023], 32'hFF);

    // random data with 50% valid gaps
    run_job(1279, 1'b1, 1'b1, -1, 1'b1);

    // early last on beat 100
    run_job(100, 1'b0, 1'b1, -1, 1'b1);
    check("curr_mem_100_written", shadow_curr[100], shadow_curr[100] === 8'hxx ? 32'h1 : {24'd0, shadow_curr[100]});

    // load request while accelerator busy
    acc_busy = 1'b1;
    load_req = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      check("busy_blocks_ready", s_ready, 32'd0);
      check("busy_keeps_err", err, 32'd1);
    end
    acc_busy = 1'b0;
    step();
    load_req = 1'b0;
    run_job(1279, 1'b1, 1'b1, -1, 1'b0);

    // missing last on final beat
    run_job(-1, 1'b0, 1'b1, -1, 1'b1);

    // reset mid-job at beat 600, then a fresh job
    run_job(1279, 1'b1, 1'b1, 600, 1'b1);
    run_job(1279, 1'b0, 1'b1, -1, 1'b1);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
